// File: rtl/clk_div_gen.sv
// Programmable clock divider with independent high time and period-start tick.
// Define CLKDIV_SYNC_LOAD_EN to defer loads to the next period boundary via shadow registers.
module clk_div_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] div_in_i,
    input  logic [WIDTH-1:0] high_in_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             busy_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_div_q, a_div_d;
    logic [WIDTH-1:0] a_high_q, a_high_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic [WIDTH-1:0] c_n;

    assign wrap = (cnt_q == a_div_q);
    assign c_n  = wrap ? '0 : cnt_q + WIDTH'(1);

`ifdef CLKDIV_SYNC_LOAD_EN
    logic [WIDTH-1:0] p_div_q, p_div_d;
    logic [WIDTH-1:0] p_high_q, p_high_d;
    logic             p_vld_q, p_vld_d;

    always_comb begin
        cnt_d     = cnt_q;
        a_div_d   = a_div_q;
        a_high_d  = a_high_q;
        p_div_d   = p_div_q;
        p_high_d  = p_high_q;
        p_vld_d   = p_vld_q;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        if (!en_i || wrap) begin
            // Parked or at a period boundary: a fresh load beats the pending one.
            if (load_i) begin
                a_div_d  = div_in_i;
                a_high_d = high_in_i;
            end else if (p_vld_q) begin
                a_div_d  = p_div_q;
                a_high_d = p_high_q;
            end
            p_vld_d = 1'b0;
            if (!en_i) begin
                cnt_d = a_div_d;
            end else begin
                cnt_d     = '0;
                tick_d    = 1'b1;
                clk_out_d = (a_high_d != '0);
            end
        end else begin
            if (load_i) begin
                p_div_d  = div_in_i;
                p_high_d = high_in_i;
                p_vld_d  = 1'b1;
            end
            cnt_d     = c_n;
            clk_out_d = (c_n < a_high_q);
        end
    end

    always_ff @(posedge clk_in_i) begin
        if (rst_i) begin
            p_div_q  <= '0;
            p_high_q <= '0;
            p_vld_q  <= 1'b0;
        end else begin
            p_div_q  <= p_div_d;
            p_high_q <= p_high_d;
            p_vld_q  <= p_vld_d;
        end
    end

    assign busy_o = p_vld_q;
`else
    always_comb begin
        cnt_d     = cnt_q;
        a_div_d   = a_div_q;
        a_high_d  = a_high_q;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        if (!en_i) begin
            if (load_i) begin
                a_div_d  = div_in_i;
                a_high_d = high_in_i;
            end
            cnt_d = a_div_d;
        end else if (load_i) begin
            // Immediate load aborts the running period and restarts at count 0.
            a_div_d   = div_in_i;
            a_high_d  = high_in_i;
            cnt_d     = '0;
            tick_d    = 1'b1;
            clk_out_d = (high_in_i != '0);
        end else begin
            cnt_d     = c_n;
            clk_out_d = (c_n < a_high_q);
            tick_d    = wrap;
        end
    end

    assign busy_o = 1'b0;
`endif

    always_ff @(posedge clk_in_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            a_div_q   <= '0;
            a_high_q  <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            a_div_q   <= a_div_d;
            a_high_q  <= a_high_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: period/phase reference model plus directed pattern checks and random traffic.
module tb_clk_div_gen;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div_in;
    logic [WIDTH-1:0] high_in;
    logic             clk_out;
    logic             tick;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Reference: active period/high time, phase within period, pending setting.
    int m_div, m_hi, m_pos, m_pdiv, m_phi;
    bit m_pv;
    bit e_clk, e_tick, e_busy;

    clk_div_gen #(.WIDTH(WIDTH)) dut (
        .clk_in_i (clk),
        .rst_i    (rst),
        .en_i     (en),
        .load_i   (load),
        .div_in_i (div_in),
        .high_in_i(high_in),
        .clk_out_o(clk_out),
        .tick_o   (tick),
        .busy_o   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit l, input int d, input int h);
        if (r) begin
            m_div = 0; m_hi = 0; m_pos = 0; m_pv = 0; m_pdiv = 0; m_phi = 0;
            e_clk = 0; e_tick = 0; e_busy = 0;
            return;
        end
        if (!e) begin
            if (l) begin
                m_div = d; m_hi = h;
            end else if (m_pv) begin
                m_div = m_pdiv; m_hi = m_phi;
            end
            m_pv  = 0;
            m_pos = m_div;
            e_clk = 0; e_tick = 0; e_busy = 0;
            return;
        end
`ifdef CLKDIV_SYNC_LOAD_EN
        m_pos++;
        if (m_pos > m_div) begin
            if (l) begin
                m_div = d; m_hi = h;
            end else if (m_pv) begin
                m_div = m_pdiv; m_hi = m_phi;
            end
            m_pv  = 0;
            m_pos = 0;
        end else if (l) begin
            m_pdiv = d; m_phi = h; m_pv = 1;
        end
`else
        if (l) begin
            m_div = d; m_hi = h; m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % (m_div + 1);
        end
`endif
        e_tick = (m_pos == 0);
        e_clk  = (m_pos < m_hi);
        e_busy = m_pv;
    endtask

    // One clock: drive on the falling edge, advance the model on the rising
    // edge, then compare all outputs just after it.
    task automatic step(input bit r, input bit e, input bit l, input int d, input int h);
        @(negedge clk);
        rst = r; en = e; load = l;
        div_in = WIDTH'(d); high_in = WIDTH'(h);
        @(posedge clk);
        model_step(r, e, l, d, h);
        #1;
        check("clk_out_vs_model", clk_out, e_clk);
        check("tick_vs_model", tick, e_tick);
        check("busy_vs_model", busy, e_busy);
    endtask

    // Runs n enabled steps (first optionally with a load) and checks
    // outputs against hand-written patterns, MSB = first step.
    task automatic run_pat(input int n, input bit load_first, input int d, input int h,
                           input logic [15:0] cpat, input logic [15:0] tpat,
                           input logic [15:0] bpat, input string name);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, load_first && (i == 0), d, h);
            check({name, "_clk"}, clk_out, cpat[n-1-i]);
            check({name, "_tick"}, tick, tpat[n-1-i]);
            check({name, "_busy"}, busy, bpat[n-1-i]);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; div_in = '0; high_in = '0;
        m_div = 0; m_hi = 0; m_pos = 0; m_pdiv = 0; m_phi = 0; m_pv = 0;
        e_clk = 0; e_tick = 0; e_busy = 0;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("reset_clk", clk_out, 1'b0);
        check("reset_tick", tick, 1'b0);
        check("reset_busy", busy, 1'b0);

        run_pat(4, 0, 0, 0, 16'b0000, 16'b1111, 16'b0000, "post_reset");

        step(0, 0, 1, 3, 2);
        run_pat(8, 0, 0, 0, 16'b11001100, 16'b10001000, 16'b0, "div3_high2");

        step(0, 0, 1, 4, 2);
        run_pat(5, 0, 0, 0, 16'b11000, 16'b10000, 16'b0, "div4_high2");
        step(0, 0, 1, 4, 0);
        run_pat(5, 0, 0, 0, 16'b00000, 16'b10000, 16'b0, "high0");
        step(0, 0, 1, 4, 7);
        run_pat(5, 0, 0, 0, 16'b11111, 16'b10000, 16'b0, "high7");

        step(0, 0, 1, 7, 4);
        run_pat(3, 0, 0, 0, 16'b111, 16'b100, 16'b0, "div7_start");
`ifdef CLKDIV_SYNC_LOAD_EN
        run_pat(8, 1, 1, 1, 16'b10000101, 16'b00000101, 16'b11111000, "midload");
`else
        run_pat(8, 1, 1, 1, 16'b10101010, 16'b10101010, 16'b00000000, "midload");
`endif

        // Reset at count 5 with a load in flight: pending setting must vanish.
        step(0, 0, 1, 7, 4);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        step(1, 1, 0, 0, 0);
        check("rst_mid_clk", clk_out, 1'b0);
        check("rst_mid_tick", tick, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        run_pat(3, 0, 0, 0, 16'b000, 16'b111, 16'b000, "after_rst");

        for (int i = 0; i < 3000; i++) begin
            bit r, e, l;
            r = ($urandom_range(199) == 0);
            e = ($urandom_range(9) != 0);
            l = ($urandom_range(7) == 0);
            step(r, e, l, int'($urandom_range(9)), int'($urandom_range(12)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
